gray_decode_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational `gray_decoder` instance (4-bit Gray in, 4-bit binary out) between up to `N_REQ` requesters. Each requester offers a Gray code over a valid/ready handshake. The block grants one requester at a time, decodes its code, and holds the registered result with the requester ID on a single response port until the consumer accepts it. It sits between the position/counter sources that produce Gray codes and the downstream logic that consumes binary values.

---
 rtl/gray_decode_arbiter.sv | 118 +++++++++++
 tb/tb_gray_decode_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/gray_decode_arbiter.sv
// rtl/gray_decode_arbiter.sv - round-robin arbiter sharing one Gray-to-binary decoder
//
// gray_decoder: 4-bit Gray code in (gray), 4-bit binary out (binary), combinational.
//
// gray_decode_arbiter ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid[N_REQ]        requester i offers a code
//   req_gray[4*N_REQ]       requester i code on bits [4i+3:4i]
//   req_ready[N_REQ]        one-hot acceptance strobe (IDLE only)
//   rsp_valid               registered response is held
//   rsp_binary[4], rsp_id   decoded value and the requester that supplied it
//   rsp_ready               consumer accepts the response

module gray_decoder (
    input  logic [3:0] gray,
    output logic [3:0] binary
);
    always_comb begin
        binary[3] = gray[3];
        binary[2] = binary[3] ^ gray[2];
        binary[1] = binary[2] ^ gray[1];
        binary[0] = binary[1] ^ gray[0];
    end
endmodule

module gray_decode_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [4*N_REQ-1:0]   req_gray,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 rsp_valid,
    output logic [3:0]           rsp_binary,
    output logic [ID_W-1:0]      rsp_id,
    input  logic                 rsp_ready
);
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   winner;
    logic              found;
    logic [ID_W-1:0]   cand;
    int                idx;
    logic [3:0]        sel_gray;
    logic [3:0]        dec_binary;

    // Search starts one past the previous winner and wraps, so the most
    // recently served requester always has the lowest priority.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        cand   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx  = (int'(last_grant) + k) % N_REQ;
            cand = ID_W'(idx);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign sel_gray = req_gray[{winner, 2'b00} +: 4];

    gray_decoder u_gray_decoder (
        .gray   (sel_gray),
        .binary (dec_binary)
    );

    // Ready never looks at rsp_ready, which keeps the consumer out of any
    // combinational path back to the requesters.
    always_comb begin
        req_ready  = '0;
        state_next = state;
        case (state)
            IDLE: begin
                if (found) begin
                    req_ready[winner] = 1'b1;
                    state_next        = BUSY;
                end
            end
            BUSY: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Derived from state so an asynchronous reset drops it at once.
    assign rsp_valid = (state == BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= ID_W'(N_REQ - 1);
            rsp_binary <= 4'b0000;
            rsp_id     <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && found) begin
                rsp_binary <= dec_binary;
                rsp_id     <= winner;
                last_grant <= winner;
            end
        end
    end
endmodule

// File: tb/tb_gray_decode_arbiter.sv
// tb/tb_gray_decode_arbiter.sv - directed bench for gray_decode_arbiter

module tb_gray_decode_arbiter;
    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_gray;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [3:0]  rsp_binary;
    logic [1:0]  rsp_id;
    logic        rsp_ready;

    int n_checks = 0;
    int n_errors = 0;

    gray_decode_arbiter #(.N_REQ(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_gray   (req_gray),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_binary (rsp_binary),
        .rsp_id     (rsp_id),
        .rsp_ready  (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Entered in IDLE with inputs applied; leaves in IDLE just after the
    // edge that completes the response (rsp_ready assumed high).
    task automatic do_grant(input string tag, input logic [3:0] exp_ready,
                            input logic [3:0] exp_bin, input logic [1:0] exp_id,
                            input logic [3:0] valid_after);
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(exp_ready));
        @(posedge clk); #1;
        req_valid = valid_after;
        @(negedge clk);
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_bin"}, 32'(rsp_binary), 32'(exp_bin));
        check({tag, "_id"}, 32'(rsp_id), 32'(exp_id));
        check({tag, "_busy_ready"}, 32'(req_ready), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [3:0] code;
        logic [1:0] id;
        logic [3:0] mask;

        rst_n     = 1'b0;
        req_valid = '0;
        req_gray  = '0;
        rsp_ready = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_bin", 32'(rsp_binary), 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;

        // Single request: 1011 -> 1101
        req_gray[3:0] = 4'b1011;
        req_valid     = 4'b0001;
        rsp_ready     = 1'b1;
        do_grant("single", 4'b0001, 4'b1101, 2'd0, 4'b0000);

        // Sweep all Gray codes through requester 2
        for (int i = 0; i < 16; i++) begin
            code           = 4'(i ^ (i >> 1));
            req_gray[11:8] = code;
            req_valid      = 4'b0100;
            do_grant("sweep", 4'b0100, 4'(i), 2'd2, 4'b0000);
        end

        // Round robin from reset (last_grant = 3)
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        req_gray  = {4'b0110, 4'b0010, 4'b0011, 4'b0001};
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            id   = 2'(k);
            mask = 4'b0001 << id;
            do_grant("rr", mask, {2'b00, id} + 4'd1, id, 4'b1111);
        end
        req_valid = 4'b0000;

        // Backpressure: requester 1 with 1000 -> 1111, held 5 cycles
        req_gray[7:4]  = 4'b1000;
        req_gray[11:8] = 4'b0011;
        req_valid      = 4'b0010;
        rsp_ready      = 1'b0;
        #1;
        check("bp_grant", 32'(req_ready), 32'b0010);
        @(posedge clk); #1;
        req_valid = 4'b0110;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_bin", 32'(rsp_binary), 32'b1111);
            check("bp_id", 32'(rsp_id), 32'd1);
            check("bp_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1;
        do_grant("bp_next", 4'b0100, 4'd2, 2'd2, 4'b0000);

        // Withdrawn request: make last_grant = 0, then 1 and 3 arrive while BUSY
        req_gray[3:0] = 4'b0000;
        req_valid     = 4'b0001;
        rsp_ready     = 1'b0;
        #1;
        check("wd_setup", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        req_gray[15:12] = 4'b0110;
        req_gray[7:4]   = 4'b1000;
        req_valid       = 4'b1010;
        @(negedge clk);
        check("wd_busy_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("wd_grant", 32'(req_ready), 32'b1000);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("wd_valid", 32'(rsp_valid), 32'd1);
        check("wd_id", 32'(rsp_id), 32'd3);
        check("wd_bin", 32'(rsp_binary), 32'd4);

        // Reset while BUSY, no clock edge in between
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(rsp_valid), 32'd0);
        check("arst_bin", 32'(rsp_binary), 32'd0);
        check("arst_id", 32'(rsp_id), 32'd0);
        req_gray[3:0]  = 4'b0010;
        req_gray[11:8] = 4'b0111;
        req_valid      = 4'b0101;
        rsp_ready      = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_grant("arst_first", 4'b0001, 4'd3, 2'd0, 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
